// File: rtl/bus_pkg.sv
// Shared types and defaults for the arbitrated multi-device bus.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } bus_state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_M        = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Width of a device index; at least one bit so a 1-device build still elaborates.
    function automatic int idx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: first set req bit at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is taken.
//
// Ports:
//   req     - per-device request bits
//   rr_ptr  - device index where the search starts
//   win     - one-hot winner (all-zero when no request)
//   win_idx - index of the winner (0 when no request)
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int M = DEF_M
) (
    input  logic [M-1:0]          req,
    input  logic [idx_w(M)-1:0]   rr_ptr,
    output logic [M-1:0]          win,
    output logic [idx_w(M)-1:0]   win_idx
);

    localparam int W = idx_w(M);

    always_comb begin : search
        logic [W-1:0] idx;
        logic         found;
        win     = '0;
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < M; k++) begin
            idx = W'((int'(rr_ptr) + k) % M);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/multi_dev_bus_arbiter.sv
// Shared bus for M devices: registered round-robin grant, owner data registered onto one bus.
// Latency: grant 1 cycle after req; bus/bus_valid 1 cycle after grant (2 cycles from idle).
// Backpressure: losing requesters wait with req held high; owner keeps the bus while req stays high.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - per-device level-held request
//   data_in    - device i data at [i*N +: N]
//   grant      - registered one-hot grant (all-zero when idle)
//   bus_owner  - registered index of the grant holder, holds its value while idle
//   bus        - registered shared bus lines, bus_valid marks cycles carrying owner data
//   data_out   - bus replicated to every device slice
// Optional feature: define BUS_TENURE_LIMIT_EN to force a handoff after MAX_HOLD owned
// cycles whenever another device is waiting.
module multi_dev_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int M        = DEF_M,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M-1:0]          req,
    input  logic [M*N-1:0]        data_in,
    output logic [M-1:0]          grant,
    output logic [idx_w(M)-1:0]   bus_owner,
    output logic [N-1:0]          bus,
    output logic                  bus_valid,
    output logic [M*N-1:0]        data_out
);

    localparam int W = idx_w(M);

    bus_state_t     state, state_nxt;
    logic [M-1:0]   grant_nxt;
    logic [M-1:0]   win;
    logic [W-1:0]   win_idx;
    logic [W-1:0]   rr_ptr, ptr_nxt;
    logic [W-1:0]   owner_nxt;
    logic           take;
    logic           force_rel;
    logic           owner_req;
    logic [N-1:0]   dev_dat [M];

    for (genvar g = 0; g < M; g++) begin : g_slice
        assign dev_dat[g] = data_in[g*N +: N];
    end

    assign owner_req = req[bus_owner];
    assign data_out  = {M{bus}};

    rr_arbiter #(.M(M)) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (win),
        .win_idx (win_idx)
    );

`ifdef BUS_TENURE_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt, hold_nxt;

    // Forced release only when someone else is waiting; a lone owner just restarts its window.
    assign force_rel = (hold_cnt == CW'(MAX_HOLD)) && |(req & ~grant);

    always_comb begin
        hold_nxt = '0;
        if (take) begin
            hold_nxt = CW'(1);
        end else if (state_nxt == OWNED) begin
            hold_nxt = (hold_cnt == CW'(MAX_HOLD)) ? CW'(1) : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end
`else
    // Never true for a legal MAX_HOLD; the parameter has no effect in this build.
    assign force_rel = (MAX_HOLD < 0);
`endif

    // Next-state: a new winner is taken from idle, on a voluntary handoff, or on a forced
    // release. The owner sits last in the search order (rr_ptr = owner+1), so a forced
    // release never picks the current owner while others are pending.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = bus_owner;
        ptr_nxt   = rr_ptr;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) take = 1'b1;
            end
            OWNED: begin
                if (!owner_req) begin
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (force_rel) begin
                    take = 1'b1;
                end
            end
            default: ;
        endcase
        if (take) begin
            state_nxt = OWNED;
            grant_nxt = win;
            owner_nxt = win_idx;
            ptr_nxt   = W'((int'(win_idx) + 1) % M);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            bus_owner <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            bus_owner <= owner_nxt;
            rr_ptr    <= ptr_nxt;
        end
    end

    // Bus follows the current owner while it still requests; otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus       <= '0;
            bus_valid <= 1'b0;
        end else if ((state == OWNED) && owner_req) begin
            bus       <= dev_dat[bus_owner];
            bus_valid <= 1'b1;
        end else begin
            bus_valid <= 1'b0;
        end
    end

endmodule
